// File: rtl/mac_pkg.sv
// Shared defaults and state encoding for the mac row collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 8;
    localparam int ROW_LEN = 32;
    localparam int ACC_W   = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/mac_sat_add.sv
// Unsigned ACC_W adder that clamps to all-ones on overflow and flags it.
// Latency: combinational.
// Backpressure: n/a.
module mac_sat_add #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    logic [ACC_W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sat  = full[ACC_W];
    assign sum  = sat ? '1 : full[ACC_W-1:0];
endmodule

// File: rtl/mac_row_collector.sv
// Accumulates mac partial sums per row position, then drains the finished row.
// Latency: psum lands in the buffer at the accepting edge; drain starts the cycle after row_last.
// Backpressure: psum_ready low for the whole drain; drain holds outputs while out_ready is low.
module mac_row_collector #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int IDX_W   = mac_pkg::IDX_W,
    parameter int ROW_LEN = mac_pkg::ROW_LEN,
    parameter int ACC_W   = mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [DATA_W-1:0] psum,
    input  logic [IDX_W-1:0]  psum_idx,
    input  logic              row_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              row_sat,
    output logic              idx_err
);
    import mac_pkg::*;

    localparam int              PTR_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ROW_LEN - 1);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic             sat_flag;
    logic [ACC_W-1:0] row_buf [ROW_LEN];

    logic             accept;
    logic             idx_ok;
    logic             drain_hs;
    logic [PTR_W-1:0] wr_ptr;
    logic [ACC_W-1:0] add_sum;
    logic             add_sat;

    assign accept   = psum_valid && psum_ready;
    // Compare at 32 bits so ROW_LEN == 2**IDX_W cannot wrap to zero.
    assign idx_ok   = 32'(psum_idx) < ROW_LEN;
    assign wr_ptr   = psum_idx[PTR_W-1:0];
    assign drain_hs = out_valid && out_ready;

    mac_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (row_buf[wr_ptr]),
        .b   (ACC_W'(psum)),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            ptr        <= '0;
            sat_flag   <= 1'b0;
            psum_ready <= 1'b1;
            out_valid  <= 1'b0;
            idx_err    <= 1'b0;
        end else begin
            idx_err <= accept && !idx_ok;
            case (state)
                ACCUM: begin
                    if (accept && idx_ok && add_sat)
                        sat_flag <= 1'b1;
                    if (accept && row_last) begin
                        state      <= DRAIN;
                        ptr        <= '0;
                        psum_ready <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (ptr == LAST_PTR) begin
                            state      <= ACCUM;
                            ptr        <= '0;
                            sat_flag   <= 1'b0;
                            psum_ready <= 1'b1;
                            out_valid  <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ACCUM;
                    psum_ready <= 1'b1;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulate and drain-clear never overlap: psum_ready and out_valid are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROW_LEN; i++)
                row_buf[i] <= '0;
        end else if (accept && idx_ok) begin
            row_buf[wr_ptr] <= add_sum;
        end else if (drain_hs) begin
            row_buf[ptr] <= '0;
        end
    end

    assign out_data = out_valid ? row_buf[ptr] : '0;
    assign out_idx  = IDX_W'(ptr);
    assign out_last = out_valid && (ptr == LAST_PTR);
    assign row_sat  = sat_flag && out_last;
endmodule
